pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath library. Operands are split into B-bit lookahead blocks, and one block is resolved per pipeline stage, with the block carry registered between stages. Throughput is one operation per cycle, with valid/ready handshakes on both sides. Adds subtract mode plus carry-out and signed-overflow flags. Intended as the drop-in wide adder for ALU and accumulator datapaths where a flat N-bit lookahead is too slow.

---
 rtl/pipelined_cla_adder.sv | 177 +++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. The N-bit operands are split
//   into L = N/B lookahead blocks. Stage k resolves block k-1 with a flat
//   B-bit lookahead and registers the block carry for the next stage.
//   Operand bits that have not been used yet travel forward with the
//   transaction. Sum bits that are already resolved travel forward too.
//   Flow control uses one global enable, so a stalled output freezes every
//   stage.
//
// Parameters
//   N  operand/result width (must be a multiple of B)
//   B  lookahead block width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set present
//   in_ready   operands accepted this cycle (pipeline not stalled)
//   a, b       operands
//   cin        carry-in (ignored when sub=1)
//   sub        1: a - b, 0: a + b + cin
//   out_valid  result present
//   out_ready  consumer accepts result
//   s          sum / difference
//   cout       carry out of bit N-1 (subtract: 1 = no borrow)
//   ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int N = 32,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int L = N / B;

  if (B < 1 || N < B || (N % B) != 0) begin : g_bad_params
    $error("pipelined_cla_adder: N (%0d) must be a positive multiple of B (%0d)", N, B);
  end

  // Flat lookahead for one block: every carry is a sum of products over the
  // block's generate/propagate terms and the incoming block carry. There is
  // no ripple between the bit positions.
  function automatic logic [B:0] cla_carries(input logic [B-1:0] g,
                                             input logic [B-1:0] p,
                                             input logic         ci);
    logic [B:0] c;
    logic       term;
    logic       prod;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < B; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      for (int m = 0; m <= i; m++) begin
        prod = g[m];
        for (int j = m + 1; j <= i; j++) prod = prod & p[j];
        term = term | prod;
      end
      c[i+1] = term;
    end
    return c;
  endfunction

  logic [N-1:0] bb;
  logic         c0;
  logic         adv;

  assign bb       = sub ? ~b : b;
  assign c0       = sub | cin;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 1; k <= L; k++) begin : g_stage
    localparam int SW = k * B;   // sum bits resolved once this stage is done

    logic [B-1:0]  blk_a;
    logic [B-1:0]  blk_b;
    logic          blk_ci;
    logic [B:0]    blk_c;
    logic [B-1:0]  blk_s;
    logic          v_d;
    logic [SW-1:0] sum_d;
    logic          v_q;
    logic          c_q;
    logic [SW-1:0] sum_q;

    // ---- stage k input: live operands (k=1) or skewed registers of k-1 ----
    if (k == 1) begin : g_src
      assign blk_a  = a[B-1:0];
      assign blk_b  = bb[B-1:0];
      assign blk_ci = c0;
      assign v_d    = in_valid;
      assign sum_d  = blk_s;
    end else begin : g_src
      assign blk_a  = g_stage[k-1].g_up.a_up_q[B-1:0];
      assign blk_b  = g_stage[k-1].g_up.bb_up_q[B-1:0];
      assign blk_ci = g_stage[k-1].c_q;
      assign v_d    = g_stage[k-1].v_q;
      assign sum_d  = {blk_s, g_stage[k-1].sum_q};
    end

    assign blk_c = cla_carries(blk_a & blk_b, blk_a | blk_b, blk_ci);
    assign blk_s = blk_a ^ blk_b ^ blk_c[B-1:0];

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_d;
        c_q   <= blk_c[B];
        sum_q <= sum_d;
      end
    end

    if (k < L) begin : g_up
      localparam int UW = N - k * B;   // operand bits still to be resolved

      logic [UW-1:0] a_up_d;
      logic [UW-1:0] bb_up_d;
      logic [UW-1:0] a_up_q;
      logic [UW-1:0] bb_up_q;

      if (k == 1) begin : g_usrc
        assign a_up_d  = a[N-1:B];
        assign bb_up_d = bb[N-1:B];
      end else begin : g_usrc
        assign a_up_d  = g_stage[k-1].g_up.a_up_q[UW+B-1:B];
        assign bb_up_d = g_stage[k-1].g_up.bb_up_q[UW+B-1:B];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_up_q  <= '0;
          bb_up_q <= '0;
        end else if (adv) begin
          a_up_q  <= a_up_d;
          bb_up_q <= bb_up_d;
        end
      end
    end else begin : g_top
      // Carry into the MSB, kept so that ovf can be formed from registers.
      logic cmsb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmsb_q <= 1'b0;
        end else if (adv) begin
          cmsb_q <= blk_c[B-1];
        end
      end
    end
  end

  // ---- output: stage L registers ----
  assign out_valid = g_stage[L].v_q;
  assign s         = g_stage[L].sum_q;
  assign cout      = g_stage[L].c_q;
  assign ovf       = g_stage[L].c_q ^ g_stage[L].g_top.cmsb_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder
//   Scoreboard bench for pipelined_cla_adder. It uses three instances:
//   N=32/B=8 (main), N=8/B=8 (single stage) and N=16/B=4. Expected results
//   are queued when an operand set is accepted. A monitor per instance pops
//   and compares them whenever that instance presents an output transfer.
// ---------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  exp_t q32[$];
  exp_t q8[$];
  exp_t q16[$];

  // main instance N=32, B=8
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, s;

  pipelined_cla_adder #(.N(32), .B(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  // single-stage instance N=8, B=8
  logic       iv8, ir8, ci8, sb8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;

  pipelined_cla_adder #(.N(8), .B(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(ci8), .sub(sb8), .out_valid(ov8),
    .out_ready(or8), .s(s8), .cout(co8), .ovf(of8)
  );

  // four-stage narrow-block instance N=16, B=4
  logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;

  pipelined_cla_adder #(.N(16), .B(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(ci16), .sub(sb16), .out_valid(ov16),
    .out_ready(or16), .s(s16), .cout(co16), .ovf(of16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full-width reference: (a + bb + c0) in 33 bits; the signed-overflow rule
  // uses the operand and result sign bits.
  function automatic exp_t model32(input logic [31:0] av, input logic [31:0] bv,
                                   input logic cv, input logic sv);
    exp_t        e;
    logic [31:0] bbv;
    logic        c0v;
    logic [32:0] full;
    bbv   = sv ? ~bv : bv;
    c0v   = sv ? 1'b1 : cv;
    full  = {1'b0, av} + {1'b0, bbv} + {32'b0, c0v};
    e.s   = full[31:0];
    e.c   = full[32];
    e.o   = (av[31] == bbv[31]) && (full[31] != av[31]);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Present one operand set. The expected result is pushed on the edge that
  // accepts it. Returns #1 after that edge with in_valid still high.
  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input logic sv, input exp_t e);
    exp_t ee;
    ee       = e;
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (in_ready) begin
        ee.acc = cyc;
        q32.push_back(ee);
        #1;
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, operand a=0x%0h", av);
    #1;
  endtask

  task automatic dsend(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic sv, input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s   = es;
    e.c   = ec;
    e.o   = eo;
    e.acc = 0;
    e.lat = 1'b1;
    send(av, bv, cv, sv, e);
  endtask

  task automatic rsend(input bit lat);
    logic [31:0] av, bv;
    logic        cv, sv;
    exp_t        e;
    av    = $urandom;
    bv    = $urandom;
    cv    = 1'($urandom_range(0, 1));
    sv    = 1'($urandom_range(0, 1));
    e     = model32(av, bv, cv, sv);
    e.lat = lat;
    send(av, bv, cv, sv, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q32.size() == 0 && q8.size() == 0 && q16.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main instance: scoreboard pop, latency, stall behaviour.
  logic        stall_q = 1'b0;
  logic [31:0] hs;
  logic        hc, ho;
  exp_t        m32;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      chk("in_ready_vs_stall", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      if (stall_q) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_s", s, hs);
        chk("stall_cout", {31'b0, cout}, {31'b0, hc});
        chk("stall_ovf", {31'b0, ovf}, {31'b0, ho});
      end
      if (out_valid && out_ready) begin
        if (q32.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL extra_result32: got s=0x%0h with nothing outstanding", s);
        end else begin
          m32 = q32.pop_front();
          chk("s32", s, m32.s);
          chk("cout32", {31'b0, cout}, {31'b0, m32.c});
          chk("ovf32", {31'b0, ovf}, {31'b0, m32.o});
          if (m32.lat) chk("latency32", cyc - m32.acc, 32'd4);
        end
      end
      stall_q = out_valid && !out_ready;
      hs      = s;
      hc      = cout;
      ho      = ovf;
    end
  end

  exp_t m8;
  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL extra_result8: got s=0x%0h with nothing outstanding", s8);
      end else begin
        m8 = q8.pop_front();
        chk("s8", {24'b0, s8}, m8.s);
        chk("cout8", {31'b0, co8}, {31'b0, m8.c});
        chk("ovf8", {31'b0, of8}, {31'b0, m8.o});
        chk("latency8", cyc - m8.acc, 32'd1);
      end
    end
  end

  exp_t m16;
  always @(negedge clk) begin
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL extra_result16: got s=0x%0h with nothing outstanding", s16);
      end else begin
        m16 = q16.pop_front();
        chk("s16", {16'b0, s16}, m16.s);
        chk("cout16", {31'b0, co16}, {31'b0, m16.c});
        chk("ovf16", {31'b0, of16}, {31'b0, m16.o});
        chk("latency16", cyc - m16.acc, 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  exp_t e8, e16;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0; or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0; or16 = 1'b1;

    #3;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_s", s, 32'd0);
    chk("reset_cout", {31'b0, cout}, 32'd0);
    chk("reset_ovf", {31'b0, ovf}, 32'd0);
    chk("reset_out_valid8", {31'b0, ov8}, 32'd0);
    chk("reset_out_valid16", {31'b0, ov16}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // directed add/subtract vectors, back to back
    dsend(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    dsend(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    dsend(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    dsend(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    dsend(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    dsend(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    dsend(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    dsend(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    dsend(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    in_valid = 1'b0;

    // single-stage and narrow-block instances
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; sb8 = 1'b0; iv8 = 1'b1;
    a16 = 16'h0FFF; b16 = 16'h0001; ci16 = 1'b1; sb16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    chk("in_ready8", {31'b0, ir8}, 32'd1);
    chk("in_ready16", {31'b0, ir16}, 32'd1);
    e8.s = 32'h80; e8.c = 1'b0; e8.o = 1'b1; e8.acc = cyc; e8.lat = 1'b1;
    q8.push_back(e8);
    e16.s = 32'h1001; e16.c = 1'b0; e16.o = 1'b0; e16.acc = cyc; e16.lat = 1'b1;
    q16.push_back(e16);
    #1;
    a8 = 8'h00; b8 = 8'h01; ci8 = 1'b0; sb8 = 1'b1;
    a16 = 16'h8000; b16 = 16'h0001; ci16 = 1'b0; sb16 = 1'b1;
    @(posedge clk);
    e8.s = 32'hFF; e8.c = 1'b0; e8.o = 1'b0; e8.acc = cyc;
    q8.push_back(e8);
    e16.s = 32'h7FFF; e16.c = 1'b1; e16.o = 1'b1; e16.acc = cyc;
    q16.push_back(e16);
    #1;
    iv8  = 1'b0;
    iv16 = 1'b0;
    drain();

    // streaming: 64 random operand sets, out_ready held at 1
    for (int i = 0; i < 64; i++) rsend(1'b1);
    in_valid = 1'b0;
    drain();

    // backpressure: fill, stall, then random out_ready
    fork
      begin
        for (int i = 0; i < 24; i++) rsend(1'b0);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (7) @(posedge clk);
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with three transactions in flight, one of them at the output
    dsend(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
    dsend(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    dsend(32'h0000_0009, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    q32.delete();
    #1;
    chk("async_reset_valid", {31'b0, out_valid}, 32'd0);
    chk("async_reset_s", s, 32'd0);
    chk("async_reset_cout", {31'b0, cout}, 32'd0);
    chk("async_reset_ovf", {31'b0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("in_ready_after_mid_reset", {31'b0, in_ready}, 32'd1);
    dsend(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    drain();

    chk("leftover32", q32.size(), 32'd0);
    chk("leftover8", q8.size(), 32'd0);
    chk("leftover16", q16.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
